div_ratio_sequencer: RTL and testbench
======================================

# div_ratio_sequencer

Run-time controller for the team's clock-divider datapath: single-clock, fully synchronous replacement for ripple J-K dividers.
- Sequences a programmable divide-by-N phase counter and emits a one-cycle `tick` clock-enable per period plus a divided waveform `q_out`.
- Accepts new ratios over a valid/ready handshake and switches only at a period boundary, so no truncated or runt period is ever produced.
- Sits between the configuration/control logic and any logic clocked by the divided enable.

## Interface
- `CNT_W`, default 8: width of ratio, phase counter and burst count.
- `RST_DIV`, default 3: ratio loaded at reset.
---
- `clk_in`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  run request; level-sensitive
- `cfg_valid`  in  1  new ratio offered
- `cfg_div`  in  CNT_W  requested ratio N
- `cfg_ready`  out  1  ratio can be accepted
- `cfg_err`  out  1  one-cycle pulse: accepted ratio was illegal (N<2), discarded
- `busy`  out  1  state is RUN
- `tick`  out  1  one-cycle pulse in last phase of each period
- `q_out`  out  1  divided waveform

## Operation
States:
- IDLE: phase=0; `q_out`, `tick`, `busy` low.
- RUN: phase counts 0..N-1 and wraps.
- Transitions:
  - IDLE->RUN at the first edge with `enable`=1.
  - RUN->IDLE at a wrap edge (phase N-1 -> 0) where `enable`=0. A run always completes its current period.

Outputs:
- All outputs are decoded from registered state only; no input-to-output combinational path.
- In RUN: `q_out`=1 for phase < ceil(N/2), else 0. `tick`=1 at phase N-1.
- `cfg_err` is a registered pulse in the cycle after acceptance.

Configuration handshake:
- Transfer on any edge with `cfg_valid` && `cfg_ready`.
- `cfg_div` < 2: transfer completes, ratio is unchanged, `cfg_err` pulses.
- Legal ratio accepted in IDLE: becomes active ratio at the acceptance edge.
- Legal ratio accepted in RUN: held as pending; `cfg_ready` drops the next cycle. The pending ratio becomes active at the next wrap edge strictly after acceptance. `cfg_ready` is high again in the cycle after that wrap.
- One pending slot only.

Boundary cases:
- Acceptance on a wrap edge: the pending ratio applies at the following wrap, not that one.
- `enable` low with a ratio pending: the final wrap applies the ratio, then IDLE.
- `enable` toggling mid-period has no effect until the wrap.
- `rst_n` asserted at any time:
  - immediately forces IDLE, phase 0, active ratio=RST_DIV;
  - clears any pending ratio;
  - all outputs 0 except `cfg_ready`=1.

## Timing
- Start latency: `enable` sampled high at edge k gives phase 0 (`q_out`=1) in cycle k+1. First `tick` is in cycle k+N.
- Period is exactly N `clk_in` cycles, every period, including across ratio changes.
- Ratio-change latency: at most one full period plus one cycle after acceptance.
- Phase counter is CNT_W bits; max N = 2^CNT_W-1. Compare and wrap are unsigned, no overflow path.

## Configuration
- `DIV_BURST_EN` defined:
  - Adds input `burst_len` [CNT_W] and output `done` (1).
  - `burst_len` is sampled on the IDLE->RUN edge; value 0 means continuous.
  - Otherwise, after `burst_len` completed periods the block returns to IDLE regardless of `enable`, and `done` pulses one cycle at that wrap edge.
  - To restart, `enable` must be low for at least one cycle, then high again.
- `DIV_BURST_EN` undefined: those ports do not exist; run is continuous while `enable` is high.

## Structure
- Package `div_ctrl_pkg` holds:
  - state enum {IDLE, RUN};
  - `MIN_DIV`=2;
  - default `RST_DIV`.
- One sub-module, `div_phase_counter`: phase register, wrap detect, `q_out`/`tick` decode from active ratio.
- Top level holds the FSM, handshake, pending slot and burst counter.

## Test plan
- Reset then `enable`=1 with N=3 -> `q_out` pattern 1,1,0 repeating; `tick` in every third cycle; first `tick` 3 cycles after `enable` sampled.
- In RUN at N=3, offer `cfg_div`=4 mid-period -> `cfg_ready` low until wrap; 3-cycle period completes, then pattern 1,1,0,0.
- `cfg_div`=1 in IDLE -> handshake completes, `cfg_err` pulses once, ratio stays 3.
- Drop `enable` at phase 0 with N=5 -> 5-cycle period completes, `tick` fires, `busy` falls the next cycle.
- Assert `rst_n` low mid-period with a ratio pending -> all outputs 0 immediately, `cfg_ready`=1; after release, `enable` yields N=3 pattern.
- With `DIV_BURST_EN`, `burst_len`=2, N=4 -> exactly 2 ticks, `done` on the 8th cycle, back to IDLE while `enable` is still high.

Source files
------------

// File: rtl/div_ratio_sequencer_pkg.sv
// Shared types and constants for the divide-ratio sequencer.
// Optional feature macro used by the top level: DIV_BURST_EN.
package div_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Smallest ratio that still yields a distinct high and low phase.
    localparam int MIN_DIV = 2;

    // Ratio loaded whenever the block is reset.
    localparam int RST_DIV_DEFAULT = 3;

endpackage

// File: rtl/div_ratio_sequencer_if.sv
// Ratio-configuration handshake bundle for the divide-ratio sequencer.
// Master offers a ratio; slave reports acceptance readiness and illegal ratios.
interface div_ratio_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/div_ratio_sequencer_phase_counter.sv
// Phase counter for the divide-ratio sequencer: counts 0..N-1 while running,
// flags the last phase (tick / wrap) and decodes the divided waveform.
module div_phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] div_act,
    output logic             tick,
    output logic             q_out
);
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] high_len;

    // Last phase of the period; div_act is never below 2, so N-1 cannot underflow.
    assign tick = run && (phase == (div_act - 1'b1));

    // ceil(N/2) computed without widening: floor(N/2) plus the odd bit.
    assign high_len = (div_act >> 1) + {{(CNT_W-1){1'b0}}, div_act[0]};
    assign q_out    = run && (phase < high_len);

    // Phase advances while running, returns to 0 at the wrap and whenever idle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            phase <= '0;
        end else if (!run || tick) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end
endmodule

// File: rtl/div_ratio_sequencer.sv
// Divide-ratio sequencer top: run/idle FSM, ratio handshake with one pending
// slot applied only at period boundaries, and optional burst mode.
// Optional feature macro: DIV_BURST_EN (adds burst_len input and done output).
module div_ratio_sequencer
    import div_ctrl_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RST_DIV = RST_DIV_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   enable,
    div_ratio_sequencer_if.slave   cfg,
`ifdef DIV_BURST_EN
    input  logic [CNT_W-1:0]       burst_len,
    output logic                   done,
`endif
    output logic                   busy,
    output logic                   tick,
    output logic                   q_out
);
    state_t           state;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] pend_div;
    logic             pend_valid;
    logic             err_q;
    logic             accept;
    logic             illegal;
    logic             start_ok;
    logic             burst_stop;

    assign busy          = (state == RUN);
    assign cfg.cfg_ready = !pend_valid;
    assign cfg.cfg_err   = err_q;
    assign accept        = cfg.cfg_valid && !pend_valid;
    assign illegal       = (cfg.cfg_div < CNT_W'(MIN_DIV));

    div_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .run     (busy),
        .div_act (div_act),
        .tick    (tick),
        .q_out   (q_out)
    );

`ifdef DIV_BURST_EN
    logic [CNT_W-1:0] burst_left;
    logic             restart_hold;

    // burst_left of 0 means continuous; 1 means the current period is the last.
    assign burst_stop = tick && (burst_left == {{(CNT_W-1){1'b0}}, 1'b1});
    assign done       = burst_stop;
    assign start_ok   = !restart_hold;

    // Burst bookkeeping: load on start, count completed periods, demand an enable low phase before restart.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            burst_left   <= '0;
            restart_hold <= 1'b0;
        end else if (state == IDLE) begin
            if (enable && !restart_hold) begin
                burst_left <= burst_len;
            end
            if (!enable) begin
                restart_hold <= 1'b0;
            end
        end else if (tick) begin
            if (burst_stop) begin
                restart_hold <= 1'b1;
            end else if (burst_left > {{(CNT_W-1){1'b0}}, 1'b1}) begin
                burst_left <= burst_left - 1'b1;
            end
        end
    end
`else
    assign burst_stop = 1'b0;
    assign start_ok   = 1'b1;
`endif

    // Run/idle FSM: start on enable, stop only at a wrap so periods are never truncated.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (enable && start_ok)             state <= RUN;
                RUN:  if (tick && (!enable || burst_stop)) state <= IDLE;
                default:                                   state <= IDLE;
            endcase
        end
    end

    // Ratio handshake: immediate load when idle, otherwise park in the pending slot until the next wrap.
    always_ff @(posedge clk_in or negedge rst_n) begin
        // NOTE: pend_div is a single data register, so it is reset along with its valid flag.
        if (!rst_n) begin
            div_act    <= CNT_W'(RST_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && illegal;
            if (pend_valid && ((state == IDLE) || tick)) begin
                div_act    <= pend_div;
                pend_valid <= 1'b0;
            end
            if (accept && !illegal) begin
                if (state == IDLE) begin
                    div_act <= cfg.cfg_div;
                end else begin
                    pend_div   <= cfg.cfg_div;
                    pend_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_ratio_sequencer.sv
// Self-checking bench for div_ratio_sequencer: directed test-plan steps then
// randomized traffic, all compared against a period-level reference model.
// Build with DIV_BURST_EN defined to exercise the burst ports.
module tb_div_ratio_sequencer;
    localparam int CNT_W = 8;

    logic       clk_in;
    logic       rst_n;
    logic       enable;
    logic [7:0] burst_len;
    logic       busy;
    logic       tick;
    logic       q_out;
    logic       done_s;

    div_ratio_sequencer_if #(.CNT_W(CNT_W)) cfg_if ();

    div_ratio_sequencer #(.CNT_W(CNT_W), .RST_DIV(3)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg       (cfg_if),
`ifdef DIV_BURST_EN
        .burst_len (burst_len),
        .done      (done_s),
`endif
        .busy      (busy),
        .tick      (tick),
        .q_out     (q_out)
    );

`ifndef DIV_BURST_EN
    assign done_s = 1'b0;
`endif

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: run flag, position within period, ratio, pending queue,
    // error pulse, burst length and periods completed in this run.
    bit m_run;
    int m_pos;
    int m_n;
    int m_pend[$];
    bit m_err;
    bit m_hold;
    int m_blen;
    int m_periods;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_n = 3; m_pend.delete();
        m_err = 0; m_hold = 0; m_blen = 0; m_periods = 0;
    endtask

    function automatic bit exp_tick();
        return m_run && (m_pos == m_n - 1);
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_next();
        bit acc  = cfg_if.cfg_valid && (m_pend.size() == 0);
        bit last = exp_tick();
        int d    = int'(cfg_if.cfg_div);
        int n_nx = m_n;
        if (m_pend.size() > 0 && (!m_run || last)) n_nx = m_pend.pop_front();
        if (acc && d >= 2) begin
            if (!m_run) n_nx = d;
            else        m_pend.push_back(d);
        end
        if (!m_run) begin
            if (enable && !m_hold) begin
                m_run = 1; m_pos = 0; m_periods = 0;
`ifdef DIV_BURST_EN
                m_blen = int'(burst_len);
`else
                m_blen = 0;
`endif
            end
            if (!enable) m_hold = 0;
        end else if (last) begin
            m_pos = 0;
            m_periods++;
            if (m_blen != 0 && m_periods == m_blen) begin
                m_run = 0; m_hold = 1;
            end else if (!enable) begin
                m_run = 0;
            end
        end else begin
            m_pos++;
        end
        m_n   = n_nx;
        m_err = acc && (d < 2);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".busy"},  32'(busy),  32'(m_run));
        check({tag, ".tick"},  32'(tick),  32'(exp_tick()));
        check({tag, ".q_out"}, 32'(q_out), 32'(m_run && (m_pos < (m_n + 1) / 2)));
        check({tag, ".ready"}, 32'(cfg_if.cfg_ready), 32'(m_pend.size() == 0));
        check({tag, ".err"},   32'(cfg_if.cfg_err),   32'(m_err));
`ifdef DIV_BURST_EN
        check({tag, ".done"},  32'(done_s),
              32'(exp_tick() && m_blen != 0 && m_periods == m_blen - 1));
`endif
    endtask

    // Called at a falling edge with inputs already driven; checks after the next rising edge.
    task automatic step(input string tag);
        model_next();
        @(posedge clk_in);
        @(negedge clk_in);
        cyc++;
        compare_all(tag);
    endtask

    // Asynchronous reset between edges, checked before any clock edge occurs.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        compare_all({tag, ".held"});
    endtask

    task automatic offer(input logic [7:0] d, input string tag);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = d;
        step(tag);
        cfg_if.cfg_valid = 1'b0;
    endtask

    logic [7:0] pat;
    logic [7:0] tpat;
    int         nticks;
    int         done_at;

    initial begin
        rst_n = 1'b0; enable = 1'b0; burst_len = '0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div = '0;
        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk_in);
        rst_n = 1'b1;

        // N=3 from reset: pattern 110 repeating, first tick on the third cycle.
        enable = 1'b1;
        pat = '0; tpat = '0;
        for (int i = 0; i < 6; i++) begin
            step("n3");
            pat  = {pat[6:0], q_out};
            tpat = {tpat[6:0], tick};
        end
        check("n3.q_pattern", 32'(pat[5:0]), 32'b110110);
        check("n3.tick_pattern", 32'(tpat[5:0]), 32'b001001);

        // Ratio change mid-period: ready drops, period of 3 completes, then 1100.
        step("n3b");
        step("n3c");
        offer(8'd4, "offer4");
        check("offer4.ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        step("wrap4");
        check("wrap4.ready_back", 32'(cfg_if.cfg_ready), 32'd1);
        pat = {7'd0, q_out};
        for (int i = 0; i < 7; i++) begin
            step("n4");
            pat = {pat[6:0], q_out};
        end
        check("n4.q_pattern", 32'(pat), 32'b11001100);

        // Stop, then an illegal ratio in IDLE: handshake completes, err pulses once.
        enable = 1'b0;
        for (int i = 0; i < 8 && busy; i++) step("stop");
        check("stop.idle", 32'(busy), 32'd0);
        offer(8'd1, "bad1");
        check("bad1.err", 32'(cfg_if.cfg_err), 32'd1);
        step("bad1.after");
        check("bad1.err_once", 32'(cfg_if.cfg_err), 32'd0);

        // N=5, enable dropped at phase 0: full period runs, busy falls after tick.
        offer(8'd5, "load5");
        enable = 1'b1;
        step("n5.start");
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step("n5");
        check("n5.last_tick", 32'(tick), 32'd1);
        step("n5.end");
        check("n5.busy_fall", 32'(busy), 32'd0);

        // Reset mid-period with a pending ratio, then N=3 again.
        offer(8'd7, "load7");
        enable = 1'b1;
        step("n7.a");
        step("n7.b");
        offer(8'd6, "pend6");
        async_reset("rst_pend");
        pat = '0;
        for (int i = 0; i < 3; i++) begin
            step("post_rst");
            pat = {pat[6:0], q_out};
        end
        check("post_rst.q_pattern", 32'(pat[2:0]), 32'b110);

`ifdef DIV_BURST_EN
        // Burst of 2 periods at N=4 with enable held high.
        enable = 1'b0;
        for (int i = 0; i < 8 && busy; i++) step("bstop");
        offer(8'd4, "bload4");
        burst_len = 8'd2;
        enable    = 1'b1;
        nticks = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            step("burst");
            if (tick) nticks++;
            if (done_s) done_at = i;
        end
        check("burst.ticks", 32'(nticks), 32'd2);
        check("burst.done_cycle", 32'(done_at), 32'd8);
        check("burst.idle_en_high", 32'(busy), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            enable           = ($urandom_range(0, 99) < 85);
            cfg_if.cfg_valid = ($urandom_range(0, 99) < 20);
            cfg_if.cfg_div   = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 9))
                                                           : 8'($urandom_range(0, 40));
            burst_len        = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
            else                              step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
